// File: rtl/mem_defs.sv
`default_nettype none
// ============================================================================
// mem_defs : memory-op encodings and address constants for the M stage
// Rev 1.0
// ============================================================================
package mem_defs;

  // Bit 3 of a memop marks a store.
  localparam logic [3:0] MEMOP_NONE = 4'h0;
  localparam logic [3:0] MEMOP_LW   = 4'h1;
  localparam logic [3:0] MEMOP_LH   = 4'h2;
  localparam logic [3:0] MEMOP_LHU  = 4'h3;
  localparam logic [3:0] MEMOP_LB   = 4'h4;
  localparam logic [3:0] MEMOP_LBU  = 4'h5;
  localparam logic [3:0] MEMOP_SW   = 4'h9;
  localparam logic [3:0] MEMOP_SH   = 4'hA;
  localparam logic [3:0] MEMOP_SB   = 4'hC;

  localparam logic [31:0] PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] DM_BASE    = 32'h0000_0000;

  function automatic logic memop_is_store(input logic [3:0] op);
    return (op == MEMOP_SW) || (op == MEMOP_SH) || (op == MEMOP_SB);
  endfunction

  function automatic logic memop_is_word(input logic [3:0] op);
    return (op == MEMOP_LW) || (op == MEMOP_SW);
  endfunction

  function automatic logic memop_is_half(input logic [3:0] op);
    return (op == MEMOP_LH) || (op == MEMOP_LHU) || (op == MEMOP_SH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/m_stage_dm_lane_ext.sv
`default_nettype none
// ============================================================================
// dm_lane_ext : load lane select and sign/zero extension (pure combinational)
// Rev 1.0
// ============================================================================
module dm_lane_ext
  import mem_defs::*;
(
  input  logic [3:0]  memop,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = byte_off[1] ? word[31:16] : word[15:0];
    w_byte = word[{byte_off, 3'b000} +: 8];
    data   = '0;
    case (memop)
      MEMOP_LW:  data = word;
      MEMOP_LH:  data = {{16{w_half[15]}}, w_half};
      MEMOP_LHU: data = {16'h0000, w_half};
      MEMOP_LB:  data = {{24{w_byte[7]}}, w_byte};
      MEMOP_LBU: data = {24'h000000, w_byte};
      default:   data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/m_stage_dm.sv
`default_nettype none
// ============================================================================
// m_stage_dm : M-stage data memory with post-reset clear sequencer
// Optional store trace: define DM_WRITE_TRACE_EN
// Rev 1.0
// ============================================================================
module m_stage_dm
  import mem_defs::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int ADDR_W      = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_PC,
  input  logic [3:0]  M_memop,
  input  logic [31:0] M_addr,
  input  logic [31:0] M_wdata,
  output logic [31:0] M_rdata,
  output logic        busy,
  output logic        M_fault,
  output logic        fault_sticky
);

  localparam logic [0:0]        S_CLEAR      = 1'b0;
  localparam logic [0:0]        S_RUN        = 1'b1;
  localparam logic [31:0]       c_DM_BYTES   = 32'(4 * DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] c_LAST_WORD  = ADDR_W'(DEPTH_WORDS - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_fault_sticky;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_run;
  logic [ADDR_W-1:0] w_idx;
  logic              w_oor;
  logic              w_misaligned;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;
  logic              w_store_en;
  logic              w_unused_pc;

  assign w_run        = (r_state == S_RUN);
  assign w_idx        = M_addr[ADDR_W+1:2];
  assign w_oor        = (M_addr >= c_DM_BYTES);
  assign w_misaligned = (memop_is_word(M_memop) && (M_addr[1:0] != 2'b00)) ||
                        (memop_is_half(M_memop) && M_addr[0]);
  assign M_fault      = w_run && (M_memop != MEMOP_NONE) && (w_oor || w_misaligned);
  assign busy         = !w_run;
  assign fault_sticky = r_fault_sticky;
  assign w_unused_pc  = ^M_PC;

  // Upper address bits alias into the array, so never read past the range check.
  assign w_rd_word = w_oor ? 32'h0 : r_mem[w_idx];

  dm_lane_ext u_lane_ext (
    .memop    (M_memop),
    .byte_off (M_addr[1:0]),
    .word     (w_rd_word),
    .data     (w_load)
  );

  assign M_rdata = (w_run && !M_fault) ? w_load : 32'h0;

  always_comb begin
    w_merged = w_rd_word;
    case (M_memop)
      MEMOP_SW: w_merged = M_wdata;
      MEMOP_SH: begin
        if (M_addr[1]) w_merged[31:16] = M_wdata[15:0];
        else           w_merged[15:0]  = M_wdata[15:0];
      end
      MEMOP_SB: w_merged[{M_addr[1:0], 3'b000} +: 8] = M_wdata[7:0];
      default:  w_merged = w_rd_word;
    endcase
  end

  assign w_store_en = w_run && memop_is_store(M_memop) && !M_fault;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_CLEAR;
      r_ptr          <= '0;
      r_fault_sticky <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == c_LAST_WORD) begin
            r_state <= S_RUN;
            r_ptr   <= '0;
          end
        end
        default: begin
          if (M_fault) r_fault_sticky <= 1'b1;
        end
      endcase
    end
  end

  // Array has no reset; the clear sequencer owns the write port until RUN.
  always_ff @(posedge clk) begin
    if (!w_run)          r_mem[r_ptr] <= 32'h0;
    else if (w_store_en) r_mem[w_idx] <= w_merged;
  end

`ifdef DM_WRITE_TRACE_EN
  always @(posedge clk) begin
    if (reset && w_store_en)
      $display("%d@%h: *%h <= %h", $time, M_PC, {M_addr[31:2], 2'b00}, w_merged);
  end
`endif

endmodule
`default_nettype wire
